seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, multi-cycle successor to the datapath ALU. Accepts one operation per `start` pulse on operands Y and B, and executes logic, shift, rotate, add, subtract, negate, not, increment and branch-target operations in one cycle. Signed multiply and divide run iteratively over WIDTH cycles. Results are registered and held on a 2*WIDTH-bit output (HI:LO) for capture into Z, with a start/busy/done handshake to the control unit.

## Interface
- WIDTH, 32, operand width; power of two, 8..64
- SHW, $clog2(WIDTH), shift/rotate amount bits used
- clock  in  1  rising-edge clock
- clear  in  1  synchronous active-high reset
- start  in  1  launch operation; sampled only when busy=0
- op  in  5  opcode (shared encoding, see Structure)
- y  in  WIDTH  first operand (Y register)
- b  in  WIDTH  second operand (bus)
- con_flag  in  1  branch condition
- busy  out  1  multi-cycle operation in progress
- done  out  1  one-cycle pulse: result valid this cycle and after
- result  out  2*WIDTH  {HI, LO}; held until next accepted start
- div_zero  out  1  sticky for the last divide; set when b==0

## Operation
- Operands and op are latched on the accepted start; later input changes are ignored.
- Single-cycle ops (HI=0 unless stated):
  - OR/ORI: y|b. AND/ANDI: y&b. NOT: ~b. NEG: -b. INC: b+1.
  - ADD/ADDI/LD/LDI/ST: y+b. SUB: y-b. All modulo 2^WIDTH.
  - SHR/SHL: logical shift by b. If b>=WIDTH (any upper bit set) → 0.
  - SHRA: arithmetic shift. If b>=WIDTH → all copies of y[WIDTH-1].
  - ROR/ROL: rotate by b[SHW-1:0], i.e. the amount modulo WIDTH.
  - BRANCH: con_flag ? y+b : y.
- Other opcodes (JR, JAL, IN, OUT, MFHI, MFLO, NOP, HALT, undefined): result=0, done still pulses.
- MUL: signed radix-2 Booth, two's complement, full 2*WIDTH product.
- DIV: signed non-restoring.
  - LO = quotient, truncated toward zero; HI = remainder, with the sign of y.
  - Final sign-correction cycle.
  - Most-negative / -1 → LO = most-negative, HI=0 (wrap, no flag).
  - b==0 → no iteration; LO = all ones, HI = y, div_zero=1.
- div_zero is cleared by any accepted DIV with b!=0 and by clear. Non-divide ops leave it unchanged.
- FSM:
  - IDLE → DONE on a single-cycle op or DIV by zero.
  - IDLE → MUL or DIV otherwise.
  - MUL: WIDTH iterations → DONE.
  - DIV: WIDTH iterations → FIX → DONE.
  - DONE → IDLE, or directly accepts a new start (back-to-back allowed).
- An iteration counter of SHW+1 bits counts down from WIDTH. The terminal iteration is count==1.

## Timing
- Reset values: busy=0, done=0, result=0, div_zero=0, state IDLE, counter 0.
- Start accepted at edge N:
  - Single-cycle op: done=1 and result valid in cycle N+1; busy never asserted.
  - MUL: busy=1 in cycles N+1..N+WIDTH; done at N+WIDTH+1.
  - DIV: busy=1 in cycles N+1..N+WIDTH+1; done at N+WIDTH+2.
- busy and done are never high together. done lasts exactly one cycle.
- start while busy=1: ignored, no queuing.
- start in the done cycle: accepted; result stays the old value until the new done.
- result is updated only in the cycle done rises; it is stable otherwise.
- clear at any cycle, including mid-MUL/DIV, wins over start. Next cycle: IDLE, busy=0, done=0, result=0. The aborted operation produces no done.

## Structure
- Shared package/header `alu_defs`:
  - the 5-bit opcode localparams (encodings unchanged from the current datapath);
  - FSM state encoding (IDLE, MUL, DIV, FIX, DONE).
- One sub-module `seq_muldiv_core`, parametrised by WIDTH:
  - shared 2*WIDTH+1 shift register and WIDTH+1 adder;
  - mode input, load/step/fix controls;
  - outputs product or quotient/remainder.
- The top contains the FSM, counter, single-cycle datapath, operand latches and result register.

## Test plan
- Reset then ADD y=5, b=7 at edge N → done at N+1, result=64'h0000_0000_0000_000C, busy stays 0.
- MUL y=-3, b=7 (WIDTH=32) → busy for 32 cycles, done at N+33, result=64'hFFFF_FFFF_FFFF_FFEB. Also 0x8000_0000 × 0x8000_0000 → 64'h4000_0000_0000_0000.
- DIV y=-7, b=2 → done at N+34, LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF, div_zero=0. DIV y=9, b=0 → done at N+1, LO=32'hFFFF_FFFF, HI=9, div_zero=1.
- ROR y=0x8000_0001 b=1 → LO 0xC000_0000. ROL b=33 → same as b=1. SHR b=32 → 0. SHRA y=0x8000_0000 b=40 → 0xFFFF_FFFF.
- Start MUL, pulse start with ADD at N+5 → ignored, MUL done at N+33 with product. Then ADD launched in that done cycle → done at N+34.
- Assert clear at N+10 of a DIV → cycle after: busy=0, done=0, result=0, no done pulse follows. Repeat at WIDTH=8: DIV -128/-1 → LO=8'h80, HI=0, done at N+10.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared ALU definitions: datapath opcode encodings and the sequencer state encoding.
package alu_defs;

    localparam logic [4:0] OP_LD     = 5'd0;
    localparam logic [4:0] OP_LDI    = 5'd1;
    localparam logic [4:0] OP_ST     = 5'd2;
    localparam logic [4:0] OP_ADD    = 5'd3;
    localparam logic [4:0] OP_SUB    = 5'd4;
    localparam logic [4:0] OP_AND    = 5'd5;
    localparam logic [4:0] OP_OR     = 5'd6;
    localparam logic [4:0] OP_SHR    = 5'd7;
    localparam logic [4:0] OP_SHRA   = 5'd8;
    localparam logic [4:0] OP_SHL    = 5'd9;
    localparam logic [4:0] OP_ROR    = 5'd10;
    localparam logic [4:0] OP_ROL    = 5'd11;
    localparam logic [4:0] OP_ADDI   = 5'd12;
    localparam logic [4:0] OP_ANDI   = 5'd13;
    localparam logic [4:0] OP_ORI    = 5'd14;
    localparam logic [4:0] OP_MUL    = 5'd15;
    localparam logic [4:0] OP_DIV    = 5'd16;
    localparam logic [4:0] OP_NEG    = 5'd17;
    localparam logic [4:0] OP_NOT    = 5'd18;
    localparam logic [4:0] OP_BRANCH = 5'd19;
    localparam logic [4:0] OP_JR     = 5'd20;
    localparam logic [4:0] OP_JAL    = 5'd21;
    localparam logic [4:0] OP_IN     = 5'd22;
    localparam logic [4:0] OP_OUT    = 5'd23;
    localparam logic [4:0] OP_MFHI   = 5'd24;
    localparam logic [4:0] OP_MFLO   = 5'd25;
    localparam logic [4:0] OP_NOP    = 5'd26;
    localparam logic [4:0] OP_HALT   = 5'd27;
    localparam logic [4:0] OP_INC    = 5'd28;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_e;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative signed multiply (radix-2 Booth) and divide (non-restoring on magnitudes)
// sharing one 2*WIDTH+1 shift register and one WIDTH+1 adder.
module seq_muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               mode_i,
    input  logic               step_i,
    input  logic               fix_i,
    input  logic [WIDTH-1:0]   y_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] res_o
);
    localparam int W = WIDTH;

    // MUL layout {A[W-1:0], Q[W-1:0], q_m1}; DIV layout {A[W:0], Q[W-1:0]}
    logic [2*W:0] sr_q, sr_d;
    logic [W:0]   m_q, m_d;
    logic         div_q, qneg_q, rneg_q;
    logic [W:0]   add_a, add_b, sum;
    logic         sub;
    logic [W-1:0] y_abs, b_abs, rem_u, quo_u;

    assign y_abs = y_i[W-1] ? -y_i : y_i;
    assign b_abs = b_i[W-1] ? -b_i : b_i;

    always_comb begin
        add_a = '0;
        add_b = '0;
        sub   = 1'b0;
        if (!div_q) begin
            add_a = {sr_q[2*W], sr_q[2*W:W+1]};
            case (sr_q[1:0])
                2'b01:   add_b = m_q;
                2'b10: begin
                    add_b = m_q;
                    sub   = 1'b1;
                end
                default: add_b = '0;
            endcase
        end else if (fix_i) begin
            // negative partial remainder gets one restoring add
            add_a = sr_q[2*W:W];
            add_b = sr_q[2*W] ? m_q : '0;
        end else begin
            add_a = sr_q[2*W-1:W-1];
            add_b = m_q;
            sub   = ~sr_q[2*W];
        end
    end

    assign sum = add_a + (sub ? ~add_b : add_b) + (W+1)'(sub);

    always_comb begin
        sr_d = sr_q;
        m_d  = m_q;
        if (load_i) begin
            if (mode_i) begin
                sr_d = {{(W+1){1'b0}}, y_abs};
                m_d  = {1'b0, b_abs};
            end else begin
                sr_d = {{W{1'b0}}, y_i, 1'b0};
                m_d  = {b_i[W-1], b_i};
            end
        end else if (step_i) begin
            sr_d = div_q ? {sum, sr_q[W-2:0], ~sum[W]} : {sum, sr_q[W:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q   <= '0;
            m_q    <= '0;
            div_q  <= 1'b0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            sr_q <= sr_d;
            m_q  <= m_d;
            if (load_i) begin
                div_q  <= mode_i;
                qneg_q <= y_i[W-1] ^ b_i[W-1];
                rneg_q <= y_i[W-1];
            end
        end
    end

    assign rem_u = sum[W-1:0];
    assign quo_u = sr_q[W-1:0];

    // MUL: product after the current step; DIV: sign-corrected {rem, quo} during fix
    assign res_o = div_q ? {rneg_q ? -rem_u : rem_u, qneg_q ? -quo_u : quo_u}
                         : {sum, sr_q[W:2]};

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative signed MUL/DIV,
// with a start/busy/done handshake and a registered {HI, LO} result.
module seq_alu
    import alu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               clock_i,
    input  logic               clear_i,
    input  logic               start_i,
    input  logic [4:0]         op_i,
    input  logic [WIDTH-1:0]   y_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               con_flag_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] result_o,
    output logic               div_zero_o
);
    state_e               state_q;
    logic [SHW:0]         cnt_q;
    logic                 busy_q, done_q, div_zero_q;
    logic [2*WIDTH-1:0]   result_q, md_res;
    logic                 accept, is_mul, is_div, b_zero, md_load, md_step, md_fix;
    logic [SHW-1:0]       sh;
    logic [SHW:0]         sh_inv;
    logic                 big;
    logic [WIDTH-1:0]     ror_v, rol_v, alu_lo;

    assign accept  = start_i && (state_q == S_IDLE || state_q == S_DONE);
    assign is_mul  = (op_i == OP_MUL);
    assign is_div  = (op_i == OP_DIV);
    assign b_zero  = (b_i == '0);
    assign md_load = accept && (is_mul || (is_div && !b_zero));
    assign md_step = (state_q == S_MUL) || (state_q == S_DIV);
    assign md_fix  = (state_q == S_FIX);

    seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk_i  (clock_i),
        .rst_i  (clear_i),
        .load_i (md_load),
        .mode_i (is_div),
        .step_i (md_step),
        .fix_i  (md_fix),
        .y_i    (y_i),
        .b_i    (b_i),
        .res_o  (md_res)
    );

    assign sh     = b_i[SHW-1:0];
    assign big    = |b_i[WIDTH-1:SHW];
    // a shift by WIDTH yields 0, so sh==0 rotates cleanly
    assign sh_inv = (SHW+1)'(WIDTH) - {1'b0, sh};
    assign ror_v  = (y_i >> sh) | (y_i << sh_inv);
    assign rol_v  = (y_i << sh) | (y_i >> sh_inv);

    always_comb begin
        alu_lo = '0;
        case (op_i)
            OP_OR, OP_ORI:                        alu_lo = y_i | b_i;
            OP_AND, OP_ANDI:                      alu_lo = y_i & b_i;
            OP_NOT:                               alu_lo = ~b_i;
            OP_NEG:                               alu_lo = -b_i;
            OP_INC:                               alu_lo = b_i + WIDTH'(1);
            OP_ADD, OP_ADDI, OP_LD, OP_LDI, OP_ST: alu_lo = y_i + b_i;
            OP_SUB:                               alu_lo = y_i - b_i;
            OP_SHR:                               alu_lo = big ? '0 : y_i >> sh;
            OP_SHL:                               alu_lo = big ? '0 : y_i << sh;
            OP_SHRA:                              alu_lo = big ? {WIDTH{y_i[WIDTH-1]}}
                                                               : WIDTH'($signed(y_i) >>> sh);
            OP_ROR:                               alu_lo = ror_v;
            OP_ROL:                               alu_lo = rol_v;
            OP_BRANCH:                            alu_lo = con_flag_i ? y_i + b_i : y_i;
            default:                              alu_lo = '0;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (clear_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    if (accept) begin
                        if (md_load) begin
                            state_q <= is_div ? S_DIV : S_MUL;
                            busy_q  <= 1'b1;
                            cnt_q   <= (SHW+1)'(WIDTH);
                            if (is_div) div_zero_q <= 1'b0;
                        end else begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            result_q <= is_div ? {y_i, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, alu_lo};
                            if (is_div) div_zero_q <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q == (SHW+1)'(1)) begin
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= md_res;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q - (SHW+1)'(1);
                    end
                end
                S_DIV: begin
                    if (cnt_q == (SHW+1)'(1)) begin
                        state_q <= S_FIX;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - (SHW+1)'(1);
                    end
                end
                S_FIX: begin
                    state_q  <= S_DONE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    result_q <= md_res;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32 and WIDTH=8 with hand-computed expectations.
module tb_seq_alu;
    import alu_defs::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        clear, st32, st8, con;
    logic [4:0]  op;
    logic [31:0] y32, b32;
    logic [7:0]  y8, b8;
    logic        busy32, done32, dz32, busy8, done8, dz8;
    logic [63:0] res32;
    logic [15:0] res8;
    int          checks = 0, errors = 0;
    int          lat, bc, seen;

    seq_alu #(.WIDTH(32)) u32 (
        .clock_i(clk), .clear_i(clear), .start_i(st32), .op_i(op), .y_i(y32), .b_i(b32),
        .con_flag_i(con), .busy_o(busy32), .done_o(done32), .result_o(res32), .div_zero_o(dz32));

    seq_alu #(.WIDTH(8)) u8 (
        .clock_i(clk), .clear_i(clear), .start_i(st8), .op_i(op), .y_i(y8), .b_i(b8),
        .con_flag_i(con), .busy_o(busy8), .done_o(done8), .result_o(res8), .div_zero_o(dz8));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one op and wait for done; l = cycles from the accepting edge to done.
    task automatic run(input bit w8, input logic [4:0] o, input logic [63:0] yy,
                       input logic [63:0] bb, input logic cf, output int l, output int bcnt);
        op = o; y32 = yy[31:0]; b32 = bb[31:0]; y8 = yy[7:0]; b8 = bb[7:0]; con = cf;
        st32 = ~w8; st8 = w8;
        step();
        st32 = 1'b0; st8 = 1'b0;
        l = 1; bcnt = 0;
        while (!(w8 ? done8 : done32) && l < 200) begin
            if (w8 ? busy8 : busy32) bcnt++;
            step();
            l++;
        end
        chk("busy_at_done", {63'b0, (w8 ? busy8 : busy32)}, 64'd0);
    endtask

    task automatic sc(input string tag, input logic [4:0] o, input logic [31:0] yy,
                      input logic [31:0] bb, input logic cf, input logic [63:0] exp);
        run(1'b0, o, {32'b0, yy}, {32'b0, bb}, cf, lat, bc);
        chk({tag, "_lat"}, lat, 1);
        chk({tag, "_busy"}, bc, 0);
        chk(tag, res32, exp);
    endtask

    initial begin
        clear = 1'b1; st32 = 0; st8 = 0; con = 0; op = OP_NOP;
        y32 = 0; b32 = 0; y8 = 0; b8 = 0;
        step(); step();
        chk("rst_busy", {63'b0, busy32}, 0);
        chk("rst_done", {63'b0, done32}, 0);
        chk("rst_res", res32, 0);
        chk("rst_dz", {63'b0, dz32}, 0);
        chk("rst_res8", {48'b0, res8}, 0);
        clear = 1'b0;

        sc("add", OP_ADD, 32'd5, 32'd7, 1'b0, 64'h0000_0000_0000_000C);
        step();
        chk("done_1cyc", {63'b0, done32}, 0);
        chk("res_hold", res32, 64'hC);

        run(1'b0, OP_MUL, -64'sd3, 64'd7, 1'b0, lat, bc);
        chk("mul_lat", lat, 33);
        chk("mul_busy", bc, 32);
        chk("mul_res", res32, 64'hFFFF_FFFF_FFFF_FFEB);
        run(1'b0, OP_MUL, 64'h8000_0000, 64'h8000_0000, 1'b0, lat, bc);
        chk("mul_minmin", res32, 64'h4000_0000_0000_0000);

        run(1'b0, OP_DIV, 64'hFFFF_FFF9, 64'd2, 1'b0, lat, bc);
        chk("div_lat", lat, 34);
        chk("div_busy", bc, 33);
        chk("div_res", res32, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("div_dz", {63'b0, dz32}, 0);
        run(1'b0, OP_DIV, 64'd9, 64'd0, 1'b0, lat, bc);
        chk("div0_lat", lat, 1);
        chk("div0_res", res32, 64'h0000_0009_FFFF_FFFF);
        chk("div0_dz", {63'b0, dz32}, 1);

        sc("ror1", OP_ROR, 32'h8000_0001, 32'd1, 1'b0, 64'hC000_0000);
        chk("dz_sticky", {63'b0, dz32}, 1);
        sc("rol33", OP_ROL, 32'h8000_0001, 32'd33, 1'b0, 64'h0000_0003);
        sc("shr32", OP_SHR, 32'hFFFF_FFFF, 32'd32, 1'b0, 64'h0);
        sc("shra40", OP_SHRA, 32'h8000_0000, 32'd40, 1'b0, 64'hFFFF_FFFF);
        sc("shra4", OP_SHRA, 32'h8000_0000, 32'd4, 1'b0, 64'hF800_0000);
        sc("shl4", OP_SHL, 32'h0000_00F1, 32'd4, 1'b0, 64'h0000_0F10);
        sc("sub", OP_SUB, 32'd3, 32'd5, 1'b0, 64'hFFFF_FFFE);
        sc("br_t", OP_BRANCH, 32'd100, 32'hFFFF_FFFC, 1'b1, 64'd96);
        sc("br_f", OP_BRANCH, 32'd100, 32'hFFFF_FFFC, 1'b0, 64'd100);
        sc("neg", OP_NEG, 32'd0, 32'd1, 1'b0, 64'hFFFF_FFFF);
        sc("not", OP_NOT, 32'd0, 32'h0F0F_0000, 1'b0, 64'hF0F0_FFFF);
        sc("inc", OP_INC, 32'd0, 32'hFFFF_FFFF, 1'b0, 64'h0);
        sc("and", OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 64'h0F00_0F00);
        sc("halt", OP_HALT, 32'd5, 32'd7, 1'b0, 64'h0);

        run(1'b0, OP_DIV, 64'd100, 64'hFFFF_FFF9, 1'b0, lat, bc);
        chk("div_neg_b", res32, 64'h0000_0002_FFFF_FFF2);
        chk("dz_cleared", {63'b0, dz32}, 0);

        op = OP_MUL; y32 = 32'd6; b32 = 32'd7; st32 = 1'b1;
        step();
        st32 = 1'b0; lat = 1;
        repeat (4) begin step(); lat++; end
        op = OP_ADD; y32 = 32'd1; b32 = 32'd1; st32 = 1'b1;
        step();
        lat++; st32 = 1'b0;
        chk("ign_busy", {63'b0, busy32}, 1);
        chk("ign_done", {63'b0, done32}, 0);
        while (!done32 && lat < 200) begin step(); lat++; end
        chk("ign_lat", lat, 33);
        chk("ign_res", res32, 64'd42);
        op = OP_ADD; y32 = 32'd5; b32 = 32'd7; st32 = 1'b1;
        step();
        st32 = 1'b0;
        chk("b2b_done", {63'b0, done32}, 1);
        chk("b2b_res", res32, 64'hC);

        op = OP_DIV; y32 = 32'd100; b32 = 32'd7; st32 = 1'b1;
        step();
        st32 = 1'b0;
        repeat (9) step();
        clear = 1'b1; st32 = 1'b1; op = OP_ADD;
        step();
        st32 = 1'b0;
        chk("clr_busy", {63'b0, busy32}, 0);
        chk("clr_done", {63'b0, done32}, 0);
        chk("clr_res", res32, 0);
        clear = 1'b0;
        seen = 0;
        repeat (50) begin step(); if (done32) seen++; end
        chk("clr_nodone", seen, 0);

        run(1'b1, OP_DIV, 64'h80, 64'hFF, 1'b0, lat, bc);
        chk("div8_lat", lat, 10);
        chk("div8_res", {48'b0, res8}, 64'h0080);
        chk("div8_dz", {63'b0, dz8}, 0);
        run(1'b1, OP_MUL, 64'h80, 64'h80, 1'b0, lat, bc);
        chk("mul8_lat", lat, 9);
        chk("mul8_res", {48'b0, res8}, 64'h4000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
